// File: rtl/ternary_pkg.sv
// Shared unbalanced-ternary definitions: trit encodings, a validity check,
// and a digit/carry split for small per-position sums.
package ternary_pkg;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_INV = 2'b11;

  // One ternary position after reduction: the digit kept here and the carry
  // passed to the next position up.
  typedef struct packed {
    logic [1:0] carry;
    logic [1:0] digit;
  } trit_split_t;

  function automatic logic trit_valid(input logic [1:0] t);
    return t != TRIT_INV;
  endfunction

  // A position sum is at most 2 (acc) + 4 (digit product) + 2 (carry) = 8,
  // so the carry never exceeds 2 and a small table is enough.
  function automatic trit_split_t trit_split(input logic [3:0] s);
    trit_split_t r;
    case (s)
      4'd0:    r = '{carry: TRIT_0, digit: TRIT_0};
      4'd1:    r = '{carry: TRIT_0, digit: TRIT_1};
      4'd2:    r = '{carry: TRIT_0, digit: TRIT_2};
      4'd3:    r = '{carry: TRIT_1, digit: TRIT_0};
      4'd4:    r = '{carry: TRIT_1, digit: TRIT_1};
      4'd5:    r = '{carry: TRIT_1, digit: TRIT_2};
      4'd6:    r = '{carry: TRIT_2, digit: TRIT_0};
      4'd7:    r = '{carry: TRIT_2, digit: TRIT_1};
      4'd8:    r = '{carry: TRIT_2, digit: TRIT_2};
      default: r = '{carry: TRIT_0, digit: TRIT_0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ternary_row_mac.sv
// Combinational row step: sum = acc + a * m * 3^shift, all in ternary.
// a is N trits, m is one trit, acc/sum are 2N trits.
module ternary_row_mac
  import ternary_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 3
) (
  input  logic [2*N-1:0] a,
  input  logic [1:0]     m,
  input  logic [SW-1:0]  shift,
  input  logic [4*N-1:0] acc,
  output logic [4*N-1:0] sum
);

  logic [3:0]  p;
  logic [1:0]  carry;
  trit_split_t split;

  // Single ripple over the accumulator: each position adds its shifted
  // digit product and the incoming carry, then splits into digit/carry.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sum   = '0;
    carry = TRIT_0;
    p     = '0;
    split = '0;
    for (int j = 0; j < 2*N; j++) begin
      p = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(shift) + k == j) p = 4'(a[2*k +: 2]) * 4'(m);
      end
      split          = trit_split(4'(acc[2*j +: 2]) + p + 4'(carry));
      sum[2*j +: 2]  = split.digit;
      carry          = split.carry;
    end
  end

endmodule

// File: rtl/ternary_seq_multiplier.sv
// Sequential N x N trit multiplier: one multiplier trit per clock, LSB first,
// accumulated into a 2N-trit ternary register. Invalid trits short-circuit
// to an error result with no iterations.
module ternary_seq_multiplier
  import ternary_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           ready,
  output logic           done,
  output logic [4*N-1:0] product,
  output logic           err
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] a_q;
  logic [2*N-1:0] b_q;
  logic [4*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           inv_q;

  logic           operands_ok;
  logic [1:0]     b_trit;
  logic [4*N-1:0] acc_next;

  // Validity of the operands presented on the ports, captured at accept.
  always_comb begin
    operands_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!trit_valid(a[2*i +: 2]) || !trit_valid(b[2*i +: 2])) operands_ok = 1'b0;
    end
  end

  // Multiplier trit selected by the iteration counter.
  always_comb begin
    b_trit = TRIT_0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) b_trit = b_q[2*i +: 2];
    end
  end

  ternary_row_mac #(
    .N  (N),
    .SW (CW)
  ) u_row_mac (
    .a     (a_q),
    .m     (b_trit),
    .shift (cnt),
    .acc   (acc),
    .sum   (acc_next)
  );

  // Control FSM with registered outputs. BUSY runs cnt = 0..N-1 as
  // iterations and publishes the result on the cnt == N cycle, giving
  // done N+1 edges after accept. Invalid operands jump cnt straight to N.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      product <= '0;
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            inv_q <= !operands_ok;
            acc   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= BUSY;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == CW'(N)) begin
            product <= inv_q ? '0 : acc;
            err     <= inv_q;
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= DONE;
          end else if (inv_q) begin
            cnt <= CW'(N);
          end else begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          ready <= 1'b1;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_seq_multiplier.sv
// Directed and exhaustive checks for the N=4 ternary sequential multiplier.
`timescale 1ns/1ps
module tb_ternary_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] product;
  logic        err;

  int checks = 0;
  int errors = 0;

  ternary_seq_multiplier #(.N(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        err;
    int          lat;
    bit          pulse;
    string       name;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Integer to 8-trit unbalanced-ternary encoding.
  function automatic logic [15:0] to_tern(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[2*i +: 2] = 2'(x % 3);
      x = x / 3;
    end
    return r;
  endfunction

  // One operation from IDLE with latency, result, ready and one-shot done checks.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] ep,
                        input logic ee, input int el, input bit pulse, input string nm);
    int lat;
    int extra;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = pulse; a = 8'hFF; b = 8'hFF;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!done) check({nm, "_ready_busy"}, 32'(ready), 32'd0);
    end while (!done && lat < 12);
    start = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'(el));
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_product"}, 32'(product), 32'(ep));
    check({nm, "_err"}, 32'(err), 32'(ee));
    check({nm, "_ready_done"}, 32'(ready), 32'd1);
    extra = 0;
    repeat (7) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({nm, "_single_done"}, 32'(extra), 32'd0);
    check({nm, "_product_hold"}, 32'(product), 32'(ep));
    a = 8'h00; b = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          extra;
    logic [15:0] ta;
    logic [15:0] tb;

    vecs[0] = '{8'b00010100, 8'b00000010, 16'b0000000000101000, 1'b0, 5, 1'b0, "12x2"};
    vecs[1] = '{8'b10101010, 8'b10101010, 16'b1010100100000001, 1'b0, 5, 1'b0, "80x80"};
    vecs[2] = '{8'b00110000, 8'b00000001, 16'h0000, 1'b1, 2, 1'b0, "inv_a"};
    vecs[3] = '{8'h01, 8'hC0, 16'h0000, 1'b1, 2, 1'b0, "inv_b"};
    vecs[4] = '{8'h00, 8'hAA, 16'h0000, 1'b0, 5, 1'b0, "zero_a"};
    vecs[5] = '{8'h01, 8'h01, 16'h0001, 1'b0, 5, 1'b0, "1x1"};
    vecs[6] = '{8'h02, 8'h02, 16'h0005, 1'b0, 5, 1'b0, "2x2"};
    vecs[7] = '{8'hAA, 8'h01, 16'h00AA, 1'b0, 5, 1'b0, "80x1"};
    vecs[8] = '{8'h01, 8'h40, 16'h0040, 1'b0, 5, 1'b0, "1x27"};
    vecs[9] = '{8'h2A, 8'h02, 16'h0069, 1'b1 & 1'b0, 5, 1'b1, "26x2_pulse"};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].err, vecs[i].lat, vecs[i].pulse, vecs[i].name);

    // Reset in the middle of BUSY aborts without a done pulse.
    run_op(8'b00010100, 8'b00000010, 16'h0028, 1'b0, 5, 1'b0, "pre_abort");
    @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    run_op(8'h02, 8'h02, 16'h0005, 1'b0, 5, 1'b0, "after_abort");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_prio_ready", 32'(ready), 32'd1);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("rst_prio_no_done", 32'(extra), 32'd0);

    // Exhaustive valid pairs, issued back-to-back from the DONE cycle.
    for (int ai = 0; ai < 81; ai++) begin
      for (int bi = 0; bi < 81; bi++) begin
        ta = to_tern(ai);
        tb = to_tern(bi);
        a = ta[7:0]; b = tb[7:0]; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        do begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end while (!done && lat < 12);
        check("exh_latency", 32'(lat), 32'd5);
        check("exh_product", 32'(product), 32'(to_tern(ai * bi)));
      end
    end
    @(negedge clk);
    check("exh_done_drop", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
